// File: rtl/sync_fifo_v2.sv
// Synchronous FIFO using all DEPTH entries (any DEPTH >= 2), with optional first-word-fall-through,
// occupancy count, almost flags, write-through when full, flush and sticky error flags.
module sync_fifo_v2 #(
    parameter int WIDTH    = 256,
    parameter int DEPTH    = 8,
    parameter int FWFT     = 0,
    parameter int AF_LEVEL = DEPTH - 1,
    parameter int AE_LEVEL = 1
) (
    input  logic                 CLK,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 wr_en,
    input  logic [8*WIDTH-1:0]   data_in,
    input  logic                 rd_en,
    input  logic                 clr_err,
    output logic [8*WIDTH-1:0]   data_out,
    output logic                 data_valid,
    output logic                 full,
    output logic                 empty,
    output logic                 almost_full,
    output logic                 almost_empty,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                 overflow,
    output logic                 underflow
);

    localparam int DW = 8 * WIDTH;
    localparam int AW = ($clog2(DEPTH) > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    if (DEPTH < 2) begin : g_chk_depth
        $error("sync_fifo_v2: DEPTH must be at least 2");
    end
    if (AF_LEVEL > DEPTH) begin : g_chk_af
        $error("sync_fifo_v2: AF_LEVEL must not exceed DEPTH");
    end
    if (AE_LEVEL >= DEPTH) begin : g_chk_ae
        $error("sync_fifo_v2: AE_LEVEL must be below DEPTH");
    end

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic          rd_acc;
    logic          wr_acc;

    assign full         = (count == CW'(DEPTH));
    assign empty        = (count == '0);
    assign almost_full  = (count >= CW'(AF_LEVEL));
    assign almost_empty = (count <= CW'(AE_LEVEL));

    // A read on a full FIFO frees a slot in the same edge, so the write may proceed.
    assign rd_acc = rd_en && !empty;
    assign wr_acc = wr_en && (!full || rd_acc);

    always_ff @(posedge CLK) begin
        if (!flush && wr_acc) begin
            mem[wptr] <= data_in;
        end
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            if (clr_err) begin
                overflow  <= 1'b0;
                underflow <= 1'b0;
            end
        end else begin
            if (wr_acc) begin
                wptr <= (wptr == AW'(DEPTH - 1)) ? '0 : wptr + AW'(1);
            end
            if (rd_acc) begin
                rptr <= (rptr == AW'(DEPTH - 1)) ? '0 : rptr + AW'(1);
            end
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            // A fresh error in the same cycle overrides the clear.
            if (clr_err) begin
                overflow  <= 1'b0;
                underflow <= 1'b0;
            end
            if (wr_en && !wr_acc) begin
                overflow <= 1'b1;
            end
            if (rd_en && empty) begin
                underflow <= 1'b1;
            end
        end
    end

    if (FWFT != 0) begin : g_fwft
        assign data_out   = empty ? '0 : mem[rptr];
        assign data_valid = !empty;
    end else begin : g_std
        always_ff @(posedge CLK or negedge rst_n) begin
            if (!rst_n) begin
                data_out   <= '0;
                data_valid <= 1'b0;
            end else if (flush) begin
                data_valid <= 1'b0;
            end else if (rd_acc) begin
                data_out   <= mem[rptr];
                data_valid <= 1'b1;
            end else begin
                data_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sync_fifo_v2.sv
// Directed bench for sync_fifo_v2: a standard-mode and an FWFT instance (DEPTH=5) driven by the same stimulus.
module tb_sync_fifo_v2;

    localparam int WIDTH = 1;
    localparam int DEPTH = 5;
    localparam int CW    = 3;

    logic          CLK;
    logic          rst_n;
    logic          flush;
    logic          wr_en;
    logic [7:0]    data_in;
    logic          rd_en;
    logic          clr_err;

    logic [7:0]    s_data_out, f_data_out;
    logic          s_data_valid, f_data_valid;
    logic          s_full, f_full, s_empty, f_empty;
    logic          s_almost_full, f_almost_full, s_almost_empty, f_almost_empty;
    logic [CW-1:0] s_count, f_count;
    logic          s_overflow, f_overflow, s_underflow, f_underflow;

    int checks = 0;
    int errors = 0;

    logic [7:0] read_exp  [5] = '{8'h02, 8'h03, 8'h04, 8'h05, 8'hAA};
    logic [7:0] fwft_head [5] = '{8'h03, 8'h04, 8'h05, 8'hAA, 8'h00};

    sync_fifo_v2 #(.WIDTH(WIDTH), .DEPTH(DEPTH), .FWFT(0), .AF_LEVEL(4), .AE_LEVEL(1)) dut_std (
        .CLK(CLK), .rst_n(rst_n), .flush(flush), .wr_en(wr_en), .data_in(data_in),
        .rd_en(rd_en), .clr_err(clr_err), .data_out(s_data_out), .data_valid(s_data_valid),
        .full(s_full), .empty(s_empty), .almost_full(s_almost_full), .almost_empty(s_almost_empty),
        .count(s_count), .overflow(s_overflow), .underflow(s_underflow)
    );

    sync_fifo_v2 #(.WIDTH(WIDTH), .DEPTH(DEPTH), .FWFT(1)) dut_fwft (
        .CLK(CLK), .rst_n(rst_n), .flush(flush), .wr_en(wr_en), .data_in(data_in),
        .rd_en(rd_en), .clr_err(clr_err), .data_out(f_data_out), .data_valid(f_data_valid),
        .full(f_full), .empty(f_empty), .almost_full(f_almost_full), .almost_empty(f_almost_empty),
        .count(f_count), .overflow(f_overflow), .underflow(f_underflow)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Drive one cycle of inputs, sample 1 ns after the edge, then return inputs to idle.
    task automatic applyStimulus(input logic w, input logic [7:0] d, input logic r,
                                 input logic fl, input logic ce);
        wr_en   = w;
        data_in = d;
        rd_en   = r;
        flush   = fl;
        clr_err = ce;
        @(posedge CLK);
        #1;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        flush   = 1'b0;
        clr_err = 1'b0;
    endtask

    initial begin
        rst_n   = 1'b0;
        flush   = 1'b0;
        wr_en   = 1'b0;
        data_in = 8'h00;
        rd_en   = 1'b0;
        clr_err = 1'b0;
        #2;
        checkOutput("rst_count", s_count, 0);
        checkOutput("rst_empty", s_empty, 1);
        checkOutput("rst_full", s_full, 0);
        checkOutput("rst_valid", s_data_valid, 0);
        checkOutput("rst_dout", s_data_out, 0);
        checkOutput("rst_ovf", s_overflow, 0);
        checkOutput("rst_unf", s_underflow, 0);
        checkOutput("rst_ae", s_almost_empty, 1);
        checkOutput("rst_af", s_almost_full, 0);
        checkOutput("rst_f_valid", f_data_valid, 0);
        checkOutput("rst_f_dout", f_data_out, 0);
        #10 rst_n = 1'b1;
        @(posedge CLK);
        #1;

        $display("[TB] fill to full, check count and almost flags");
        for (int i = 1; i <= DEPTH; i++) begin
            applyStimulus(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
            checkOutput($sformatf("fill_count_%0d", i), s_count, i);
            checkOutput($sformatf("fill_ae_%0d", i), s_almost_empty, (i <= 1));
            checkOutput($sformatf("fill_af_%0d", i), s_almost_full, (i >= 4));
            checkOutput($sformatf("fill_full_%0d", i), s_full, (i == DEPTH));
        end
        checkOutput("fwft_head_full", f_data_out, 8'h01);
        checkOutput("fill_no_ovf", s_overflow, 0);

        applyStimulus(1'b1, 8'h06, 1'b0, 1'b0, 1'b0);
        checkOutput("ovf_set", s_overflow, 1);
        checkOutput("ovf_count", s_count, 5);
        checkOutput("ovf_f_set", f_overflow, 1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        checkOutput("ovf_clr", s_overflow, 0);

        $display("[TB] write-through on full");
        applyStimulus(1'b1, 8'hAA, 1'b1, 1'b0, 1'b0);
        checkOutput("wt_count", s_count, 5);
        checkOutput("wt_no_ovf", s_overflow, 0);
        checkOutput("wt_valid", s_data_valid, 1);
        checkOutput("wt_dout", s_data_out, 8'h01);
        checkOutput("wt_f_head", f_data_out, 8'h02);

        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
            checkOutput($sformatf("rd_valid_%0d", i), s_data_valid, 1);
            checkOutput($sformatf("rd_dout_%0d", i), s_data_out, read_exp[i]);
            checkOutput($sformatf("rd_f_head_%0d", i), f_data_out, fwft_head[i]);
        end
        checkOutput("drain_empty", s_empty, 1);
        checkOutput("drain_count", s_count, 0);
        checkOutput("drain_f_valid", f_data_valid, 0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        checkOutput("idle_valid", s_data_valid, 0);
        checkOutput("idle_hold", s_data_out, 8'hAA);

        $display("[TB] simultaneous write and read on empty");
        applyStimulus(1'b1, 8'h33, 1'b1, 1'b0, 1'b0);
        checkOutput("we_unf", s_underflow, 1);
        checkOutput("we_valid", s_data_valid, 0);
        checkOutput("we_count", s_count, 1);
        checkOutput("we_f_unf", f_underflow, 1);
        checkOutput("we_f_valid", f_data_valid, 1);
        checkOutput("we_f_dout", f_data_out, 8'h33);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        checkOutput("we_rd_dout", s_data_out, 8'h33);
        checkOutput("we_rd_valid", s_data_valid, 1);
        checkOutput("we_f_empty", f_empty, 1);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        checkOutput("err_wins_clr", s_underflow, 1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        checkOutput("unf_clr", s_underflow, 0);

        $display("[TB] FWFT fall-through and pop");
        applyStimulus(1'b1, 8'h10, 1'b0, 1'b0, 1'b0);
        checkOutput("fw_valid", f_data_valid, 1);
        checkOutput("fw_dout", f_data_out, 8'h10);
        checkOutput("fw_s_valid", s_data_valid, 0);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        checkOutput("fw_pop_empty", f_empty, 1);
        checkOutput("fw_pop_dout", f_data_out, 0);
        checkOutput("fw_pop_valid", f_data_valid, 0);
        checkOutput("fw_s_dout", s_data_out, 8'h10);

        $display("[TB] flush");
        applyStimulus(1'b1, 8'h41, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h42, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h43, 1'b0, 1'b0, 1'b0);
        checkOutput("fl_pre_count", s_count, 3);
        applyStimulus(1'b1, 8'h44, 1'b1, 1'b1, 1'b0);
        checkOutput("fl_count", s_count, 0);
        checkOutput("fl_empty", s_empty, 1);
        checkOutput("fl_no_ovf", s_overflow, 0);
        checkOutput("fl_valid", s_data_valid, 0);
        checkOutput("fl_dout_kept", s_data_out, 8'h10);
        checkOutput("fl_f_count", f_count, 0);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        checkOutput("fl_no_unf", s_underflow, 0);
        applyStimulus(1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        checkOutput("fl_after_dout", s_data_out, 8'h55);

        $display("[TB] asynchronous reset mid-write");
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        checkOutput("pre_rst_unf", s_underflow, 1);
        applyStimulus(1'b1, 8'h61, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h62, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        checkOutput("pre_rst_valid", s_data_valid, 1);
        checkOutput("pre_rst_dout", s_data_out, 8'h61);
        wr_en   = 1'b1;
        data_in = 8'h63;
        #2 rst_n = 1'b0;
        #1;
        checkOutput("arst_count", s_count, 0);
        checkOutput("arst_empty", s_empty, 1);
        checkOutput("arst_valid", s_data_valid, 0);
        checkOutput("arst_dout", s_data_out, 0);
        checkOutput("arst_unf", s_underflow, 0);
        checkOutput("arst_f_count", f_count, 0);
        checkOutput("arst_f_valid", f_data_valid, 0);
        wr_en = 1'b0;
        @(negedge CLK);
        rst_n = 1'b1;
        applyStimulus(1'b1, 8'h77, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        checkOutput("post_rst_dout", s_data_out, 8'h77);
        checkOutput("post_rst_count", s_count, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sync_fifo_v2.md
Name: sync_fifo_v2

Overview:
Parametrised successor to the command-path synchronous FIFO. It uses all DEPTH entries and accepts any DEPTH >= 2, not only powers of two. It adds a first-word-fall-through (FWFT) mode, an occupancy count, programmable almost-full/almost-empty flags, write-through-when-full, synchronous flush, and sticky overflow/underflow error flags. It sits between the command decoder and downstream consumers as the standard buffering primitive.

Parameters:
WIDTH, 256, payload width in bytes; data buses are 8*WIDTH bits.
DEPTH, 8, number of entries; any integer >= 2.
FWFT, 0, 0 = standard registered-read mode; 1 = first-word-fall-through mode.
AF_LEVEL, DEPTH-1, almost_full asserts when count >= AF_LEVEL.
AE_LEVEL, 1, almost_empty asserts when count <= AE_LEVEL.

Ports:
CLK  input  1  clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous clear of pointers/count/output valid
wr_en  input  1  write request
data_in  input  8*WIDTH  write data
rd_en  input  1  read request (standard) / pop acknowledge (FWFT)
clr_err  input  1  synchronous clear of sticky error flags
data_out  output  8*WIDTH  read data
data_valid  output  1  data_out holds valid data
full  output  1  count == DEPTH
empty  output  1  count == 0
almost_full  output  1  count >= AF_LEVEL
almost_empty  output  1  count <= AE_LEVEL
count  output  $clog2(DEPTH+1)  current occupancy
overflow  output  1  sticky: write rejected
underflow  output  1  sticky: read on empty

Behaviour:
- Reset (rst_n low, asynchronous): wptr=rptr=0, count=0, data_out=0, data_valid=0, overflow=underflow=0. Memory array is not reset. Reset asserted mid-transfer discards all contents immediately.
- Pointers: width AW = max(1,$clog2(DEPTH)). Each pointer wraps from DEPTH-1 to 0 explicitly; no reliance on natural rollover.
- count is a registered up/down counter. full, empty, almost_full and almost_empty decode combinationally from count, so they change the cycle after the causing edge.
- rd_acc = rd_en && !empty.
- wr_acc = wr_en && (!full || rd_acc). Write-through: when full, a simultaneous read frees the slot and the write is accepted.
- count update: wr_acc only, +1; rd_acc only, -1; both or neither, unchanged.
- Read on empty is never satisfied by a same-cycle write. The data becomes readable the next cycle.
- Standard mode (FWFT=0):
  - On rd_acc, data_out <= mem[rptr] and data_valid <= 1 for one cycle; read latency is 1 cycle.
  - Otherwise data_valid <= 0 and data_out holds its last value.
- FWFT mode (FWFT=1):
  - data_out = mem[rptr] combinationally when !empty, else all zeros.
  - data_valid = !empty.
  - rd_en pops the head; the next entry appears in the same cycle the pointer advances.
- flush (synchronous, highest priority after reset):
  - wptr=rptr=count=0 and data_valid=0.
  - Concurrent wr_en/rd_en are ignored and do not set error flags.
  - data_out is retained in standard mode.
- Errors:
  - overflow <= 1 when wr_en && !wr_acc.
  - underflow <= 1 when rd_en && empty.
  - clr_err clears both flags. A same-cycle new error wins over clr_err.
- Parameter checks: elaboration fails if DEPTH<2, AF_LEVEL>DEPTH, or AE_LEVEL>=DEPTH.

Test Plan:
- DEPTH=5, FWFT=0: write 0x01..0x05 -> full=1, count=5. Sixth write -> overflow=1, count=5. Read 5 times -> data_out 0x01..0x05, each 1 cycle after rd_en. Then empty=1.
- DEPTH=5 full, wr_en+rd_en same cycle with data 0xAA -> count stays 5, overflow=0. 0xAA is read out after the original 5 entries (pointer wrap 4->0 exercised).
- Empty FIFO, wr_en+rd_en same cycle -> underflow=1, data_valid=0, count=1. Next-cycle read returns the written word.
- FWFT=1: write 0x10 -> next cycle data_valid=1, data_out=0x10 with no rd_en. Pop -> empty=1, data_out=0.
- AF_LEVEL=4, AE_LEVEL=1: fill 0->4 -> almost_empty deasserts at count=2, almost_full asserts at count=4.
- Flush and reset:
  - count=3 with wr_en=1, flush=1 -> count=0, empty=1, no overflow.
  - rst_n pulsed low mid-write, asynchronously -> all outputs at reset values before the next clock edge.
